pwm_timebase_counter: RTL

//  Parametrised PWM timebase: prescaled counter with up / down / up-down (centre-aligned) modes,

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_prescaler.sv | 33 +++
 rtl/pwm_timebase_counter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared mode encoding and small helpers for the PWM timebase.
// Constant definitions only; no latency or flow control.
package pwm_pkg;

    typedef logic [1:0] pwm_mode_t;

    localparam pwm_mode_t MODE_UP     = 2'b00;
    localparam pwm_mode_t MODE_DOWN   = 2'b01;
    localparam pwm_mode_t MODE_UPDOWN = 2'b10;
    localparam pwm_mode_t MODE_RSVD   = 2'b11;

    // The reserved encoding behaves as plain up-counting.
    function automatic pwm_mode_t norm_mode(input pwm_mode_t m);
        return (m == MODE_RSVD) ? MODE_UP : m;
    endfunction

    // Prescale exponents beyond the prescaler width collapse to the maximum division.
    function automatic logic [7:0] clamp_presc(input logic [7:0] req, input int cw);
        if (cw < 255 && int'(req) > cw)
            return cw[7:0];
        return req;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Power-of-two clock divider: tick once every 2^exp cycles.
// Latency: tick is combinational from the counter state.
// Backpressure: none; clr holds the counter at zero.
module pwm_prescaler #(
    parameter int PRESC_CW = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [7:0] exp,
    output logic       tick
);

    localparam logic [PRESC_CW-1:0] ONE = PRESC_CW'(1);

    logic [PRESC_CW-1:0] cnt;
    logic [PRESC_CW-1:0] mask;

    // A shift of PRESC_CW or more empties the word, so the mask saturates to all ones.
    always_comb mask = ~({PRESC_CW{1'b1}} << exp);

    assign tick = (cnt == mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + ONE;
    end

endmodule

// File: rtl/pwm_timebase_counter.sv
// PWM timebase: prescaled up/down/centre-aligned counter with shadowed period and prescale.
// Latency: count_val and ovf/unf pulses update one clk after the prescaler tick.
// Backpressure: none; en=0 or a finished one-shot freezes the count.
module pwm_timebase_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESC_CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  pwm_mode_t        mode,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] period,
    input  logic [7:0]       prescale,
    output logic [WIDTH-1:0] count_val,
    output logic             dir,
    output logic             tick,
    output logic             ovf_pulse,
    output logic             unf_pulse,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             en_q;
    pwm_mode_t        mode_act;
    logic             os_act;
    logic [WIDTH-1:0] period_act;
    logic [7:0]       presc_act;

    logic             pre_tick;
    logic             arm;
    logic             adv;
    pwm_mode_t        mode_n;
    logic [7:0]       presc_req;

    logic [WIDTH-1:0] cnt_nxt;
    logic             dir_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             upd_nxt;

    assign arm       = count_reset | (en & ~en_q);
    assign adv       = en & ~done & ~arm & pre_tick;
    assign tick      = pre_tick & en & ~done;
    assign mode_n    = norm_mode(mode);
    assign presc_req = clamp_presc(prescale, PRESC_CW);

    pwm_prescaler #(
        .PRESC_CW (PRESC_CW)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arm | ~en | done),
        .exp   (presc_act),
        .tick  (pre_tick)
    );

    // Next count/direction assuming this cycle carries a tick.
    always_comb begin
        cnt_nxt = count_val;
        dir_nxt = dir;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        case (mode_act)
            MODE_DOWN: begin
                if (count_val != '0) begin
                    cnt_nxt = count_val - ONE;
                end else begin
                    cnt_nxt = period;
                    unf_nxt = 1'b1;
                end
            end
            MODE_UPDOWN: begin
                if (period_act == '0) begin
                    cnt_nxt = '0;
                    dir_nxt = 1'b1;
                    ovf_nxt = 1'b1;
                end else if (dir) begin
                    if (count_val < period_act) begin
                        cnt_nxt = count_val + ONE;
                    end else begin
                        cnt_nxt = count_val - ONE;
                        dir_nxt = 1'b0;
                        ovf_nxt = 1'b1;
                    end
                end else begin
                    if (count_val != '0) begin
                        cnt_nxt = count_val - ONE;
                    end else begin
                        cnt_nxt = count_val + ONE;
                        dir_nxt = 1'b1;
                        unf_nxt = 1'b1;
                    end
                end
            end
            default: begin
                if (count_val < period_act) begin
                    cnt_nxt = count_val + ONE;
                end else begin
                    cnt_nxt = '0;
                    ovf_nxt = 1'b1;
                end
            end
        endcase
        upd_nxt = (mode_act == MODE_UP) ? ovf_nxt : unf_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            mode_act   <= MODE_UP;
            os_act     <= 1'b0;
            period_act <= '0;
            presc_act  <= '0;
            count_val  <= '0;
            dir        <= 1'b1;
            ovf_pulse  <= 1'b0;
            unf_pulse  <= 1'b0;
            done       <= 1'b0;
        end else begin
            en_q      <= en;
            ovf_pulse <= 1'b0;
            unf_pulse <= 1'b0;
            if (arm) begin
                mode_act   <= mode_n;
                os_act     <= one_shot;
                period_act <= period;
                presc_act  <= presc_req;
                done       <= 1'b0;
                count_val  <= (mode_n == MODE_DOWN) ? period : '0;
                dir        <= (mode_n != MODE_DOWN);
            end else if (adv) begin
                count_val <= cnt_nxt;
                dir       <= dir_nxt;
                ovf_pulse <= ovf_nxt;
                unf_pulse <= unf_nxt;
                // Shadow registers only reload at the wrap so a running period is never cut short.
                if (upd_nxt) begin
                    period_act <= period;
                    presc_act  <= presc_req;
                    if (os_act)
                        done <= 1'b1;
                end
            end
        end
    end

endmodule
